// File: rtl/sr_command_driver.sv
// Command driver for an SR flip-flop: turns requested levels into non-overlapping
// registered set/reset pulses, then reads q/q_bar back and raises sticky error flags.
module sr_command_driver #(
   parameter int HOLD_W    = 8,
   parameter int PULSE_LEN = 1,
   parameter int SETTLE    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_level,
   input  logic [HOLD_W-1:0] req_hold,
   input  logic              err_clr,
   input  logic              q,
   input  logic              q_bar,
   output logic              s,
   output logic              r,
   output logic              expected_q,
   output logic              busy,
   output logic              done,
   output logic              err_mismatch,
   output logic              err_illegal
);

   localparam int PS_MAX = (PULSE_LEN > SETTLE) ? PULSE_LEN : SETTLE;
   localparam int PS_W   = $clog2(PS_MAX + 1);
   localparam int CNT_W  = (PS_W > HOLD_W) ? PS_W : HOLD_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PULSE,
      ST_SETTLE,
      ST_CHECK,
      ST_HOLD
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               level_q, level_d;
   logic               exp_q, exp_d;
   logic               s_q, s_d;
   logic               r_q, r_d;
   logic               done_q, done_d;
   logic               mis_q, mis_d;
   logic               ill_q, ill_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      level_d = level_q;
      exp_d   = exp_q;
      done_d  = 1'b0;
      // Clear first so a detection in the same cycle overrides it.
      mis_d   = err_clr ? 1'b0 : mis_q;
      ill_d   = err_clr ? 1'b0 : ill_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               level_d = req_level;
               hold_d  = req_hold;
               if (req_level != exp_q) begin
                  exp_d   = req_level;
                  state_d = ST_PULSE;
                  cnt_d   = CNT_W'(PULSE_LEN - 1);
               end else begin
                  state_d = ST_CHECK;
               end
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_W'(SETTLE - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) state_d = ST_CHECK;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_CHECK: begin
            if (q == q_bar)         ill_d = 1'b1;
            else if (q != level_q)  mis_d = 1'b1;
            if (hold_q != '0) begin
               state_d = ST_HOLD;
               cnt_d   = CNT_W'(hold_q) - CNT_W'(1);
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // s/r derive from the next state so they are registered and mutually exclusive.
      s_d = (state_d == ST_PULSE) &&  level_d;
      r_d = (state_d == ST_PULSE) && !level_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         level_q <= 1'b0;
         exp_q   <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         level_q <= level_d;
         exp_q   <= exp_d;
         s_q     <= s_d;
         r_q     <= r_d;
         done_q  <= done_d;
         mis_q   <= mis_d;
         ill_q   <= ill_d;
      end
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign s            = s_q;
   assign r            = r_q;
   assign expected_q   = exp_q;
   assign done         = done_q;
   assign err_mismatch = mis_q;
   assign err_illegal  = ill_q;

endmodule
